// File: rtl/mpsoc_wb_spram_master.sv
// Command-driven Wishbone B3 master for the single-port RAM: one read or write
// command of 1..MAX_BURST beats, issued as a classic cycle or a linear incrementing burst.
module mpsoc_wb_spram_master #(
  parameter int AW        = 8,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [DW-1:0]   wdat,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  output logic [DW-1:0]   rdat,
  output logic            rdat_valid,
  output logic            done,
  output logic            done_err,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic [1:0]      wb_bte_o,
  output logic [2:0]      wb_cti_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic [DW-1:0]   wb_dat_i
);

  localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
  localparam logic          TMO_EN   = (TIMEOUT > 0) ? 1'b1 : 1'b0;
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_BURST);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic              we_q, we_d;
  logic [DW/8-1:0]   sel_q, sel_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     beats_q, beats_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdat_q, rdat_d;
  logic              rdat_valid_q, rdat_valid_d;

  logic              bus_s;
  logic              stb_s;
  logic              ack_s;
  logic              err_s;
  logic              tmo_hit_s;
  logic [2:0]        cti_s;

  // A zero length means one beat; oversized requests are cut to the burst limit.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    if (l == {LW{1'b0}}) begin
      clamp_len = LEN_ONE;
    end else if (l > LEN_MAX) begin
      clamp_len = LEN_MAX;
    end else begin
      clamp_len = l;
    end
  endfunction

  // Error beats the ack, and the timeout only counts cycles in which a strobe is offered.
  assign bus_s     = (state_q == S_BUS);
  assign stb_s     = bus_s & (we_q ? wdat_valid : 1'b1);
  assign err_s     = stb_s & wb_err_i;
  assign ack_s     = stb_s & wb_ack_i & ~wb_err_i;
  assign tmo_hit_s = TMO_EN & stb_s & ~wb_ack_i & ~wb_err_i & (tmo_q == TMO_LAST);

  // Cycle type: classic for single beats, incrementing burst with an end-of-burst marker.
  always_comb begin
    cti_s = 3'b000;
    if (!bus_s) begin
      cti_s = 3'b000;
    end else if (len_q == LEN_ONE) begin
      cti_s = 3'b000;
    end else if (beats_q > LEN_ONE) begin
      cti_s = 3'b010;
    end else begin
      cti_s = 3'b111;
    end
  end

  // Next-state and datapath updates for the command FSM.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    we_d         = we_q;
    sel_d        = sel_q;
    len_d        = len_q;
    beats_d      = beats_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    rdat_d       = rdat_q;
    rdat_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          len_d   = clamp_len(cmd_len);
          beats_d = clamp_len(cmd_len);
          tmo_d   = {TW{1'b0}};
          err_d   = 1'b0;
          state_d = S_BUS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUS: begin
        if (err_s) begin
          err_d   = 1'b1;
          tmo_d   = {TW{1'b0}};
          state_d = S_DONE;
        end else if (ack_s) begin
          adr_d   = adr_q + AW'(1);
          beats_d = beats_q - LEN_ONE;
          tmo_d   = {TW{1'b0}};
          if (!we_q) begin
            rdat_d       = wb_dat_i;
            rdat_valid_d = 1'b1;
          end else begin
            rdat_d = rdat_q;
          end
          if (beats_q == LEN_ONE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BUS;
          end
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (stb_s) begin
          tmo_d = tmo_q + TW'(1);
        end else begin
          tmo_d = tmo_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      adr_q        <= {AW{1'b0}};
      we_q         <= 1'b0;
      sel_q        <= {(DW/8){1'b0}};
      len_q        <= {LW{1'b0}};
      beats_q      <= {LW{1'b0}};
      tmo_q        <= {TW{1'b0}};
      err_q        <= 1'b0;
      rdat_q       <= {DW{1'b0}};
      rdat_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      len_q        <= len_d;
      beats_q      <= beats_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      rdat_q       <= rdat_d;
      rdat_valid_q <= rdat_valid_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign wdat_ready = ack_s & we_q;
  assign rdat       = rdat_q;
  assign rdat_valid = rdat_valid_q;
  assign done       = (state_q == S_DONE);
  assign done_err   = (state_q == S_DONE) & err_q;

  assign wb_adr_o = adr_q;
  assign wb_dat_o = bus_s ? wdat : {DW{1'b0}};
  assign wb_sel_o = sel_q;
  assign wb_we_o  = we_q;
  assign wb_bte_o = 2'b00;
  assign wb_cti_o = cti_s;
  assign wb_cyc_o = bus_s;
  assign wb_stb_o = stb_s;

endmodule

// File: tb/tb_mpsoc_wb_spram_master.sv
// Scoreboard bench for mpsoc_wb_spram_master: directed commands against a RAM slave model.
module tb_mpsoc_wb_spram_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int LW = 5;

  logic            HCLK;
  logic            HRESETn;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_adr;
  logic [LW-1:0]   cmd_len;
  logic [3:0]      cmd_sel;
  logic [DW-1:0]   wdat;
  logic            wdat_valid, wdat_ready;
  logic [DW-1:0]   rdat;
  logic            rdat_valid, done, done_err;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [3:0]      wb_sel_o;
  logic            wb_we_o;
  logic [1:0]      wb_bte_o;
  logic [2:0]      wb_cti_o;
  logic            wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic [DW-1:0]   wb_dat_i;

  mpsoc_wb_spram_master #(.AW(AW), .DW(DW), .MAX_BURST(16), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wdat(wdat), .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
    .rdat(rdat), .rdat_valid(rdat_valid), .done(done), .done_err(done_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // RAM slave model: zero-wait combinational ack, optional stall and error injection.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic        ack_en, err_en;
  logic [7:0]  err_adr;
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
  assign wb_err_i = wb_cyc_o & wb_stb_o & err_en & (wb_adr_o == err_adr);
  assign wb_dat_i = mem[wb_adr_o];

  always @(posedge HCLK) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && wb_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_o[b]) mem[wb_adr_o][8*b +: 8] <= wb_dat_o[8*b +: 8];
      end
    end
  end

  typedef struct packed {
    logic [7:0]  adr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_t;
  typedef struct packed {
    logic       err;
    logic [7:0] stbs;
  } done_t;

  bus_t        exp_bus[$];
  logic [31:0] exp_rdat[$];
  done_t       exp_done[$];

  int total = 0;
  int bad   = 0;
  int stb_cnt = 0;
  logic chk_idle, chk_starve, chk_end;
  bus_t  mb;
  done_t md;
  logic [31:0] mr;

  logic [31:0] wbuf [16];
  logic [31:0] rexp [16];

  // Monitor: sole owner of the counters; compares DUT outputs against queued expectations.
  always @(negedge HCLK) begin
    if (!HRESETn) stb_cnt = 0;
    else if (wb_cyc_o && wb_stb_o) stb_cnt = stb_cnt + 1;

    if (chk_idle) begin
      total++;
      if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || done !== 1'b0 ||
          done_err !== 1'b0 || rdat_valid !== 1'b0 || wdat_ready !== 1'b0 || wb_cti_o !== 3'b000) begin
        bad++;
        $display("FAIL idle_outputs got ready=%b cyc=%b stb=%b done=%b derr=%b rv=%b wr=%b cti=%b want 1 0 0 0 0 0 0 000",
                 cmd_ready, wb_cyc_o, wb_stb_o, done, done_err, rdat_valid, wdat_ready, wb_cti_o);
      end
    end

    if (chk_starve) begin
      total++;
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0 || wdat_ready !== 1'b0) begin
        bad++;
        $display("FAIL starve_hold got cyc=%b stb=%b wr=%b want cyc=1 stb=0 wr=0", wb_cyc_o, wb_stb_o, wdat_ready);
      end
    end

    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
      total++;
      if (exp_bus.size() == 0) begin
        bad++;
        $display("FAIL bus_unexpected got adr=%h cti=%b want no beat", wb_adr_o, wb_cti_o);
      end else begin
        mb = exp_bus.pop_front();
        if (wb_adr_o !== mb.adr || wb_cti_o !== mb.cti || wb_we_o !== mb.we || wb_sel_o !== mb.sel ||
            wb_bte_o !== 2'b00 || (mb.we && wb_dat_o !== mb.dat) || (mb.we && wdat_ready !== 1'b1)) begin
          bad++;
          $display("FAIL bus_beat got adr=%h cti=%b we=%b sel=%h bte=%b dat=%h wr=%b want adr=%h cti=%b we=%b sel=%h bte=00 dat=%h",
                   wb_adr_o, wb_cti_o, wb_we_o, wb_sel_o, wb_bte_o, wb_dat_o, wdat_ready,
                   mb.adr, mb.cti, mb.we, mb.sel, mb.dat);
        end
      end
    end

    if (rdat_valid) begin
      total++;
      if (exp_rdat.size() == 0) begin
        bad++;
        $display("FAIL rdat_unexpected got %h want no read beat", rdat);
      end else begin
        mr = exp_rdat.pop_front();
        if (rdat !== mr) begin
          bad++;
          $display("FAIL rdat got %h want %h", rdat, mr);
        end
      end
    end

    if (done) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected got done=1 err=%b want no done", done_err);
      end else begin
        md = exp_done.pop_front();
        if (done_err !== md.err || wb_cyc_o !== 1'b0 || stb_cnt !== int'(md.stbs)) begin
          bad++;
          $display("FAIL done got err=%b cyc=%b stb_cycles=%0d want err=%b cyc=0 stb_cycles=%0d",
                   done_err, wb_cyc_o, stb_cnt, md.err, md.stbs);
        end
      end
      stb_cnt = 0;
    end

    if (chk_end) begin
      total++;
      if (exp_bus.size() != 0 || exp_rdat.size() != 0 || exp_done.size() != 0) begin
        bad++;
        $display("FAIL leftovers got bus=%0d rdat=%0d done=%0d want 0 0 0",
                 exp_bus.size(), exp_rdat.size(), exp_done.size());
      end
    end
  end

  task automatic push_burst(input logic [7:0] adr, input int n, input logic we, input logic [3:0] sel);
    bus_t b;
    for (int i = 0; i < n; i++) begin
      b.adr = adr + 8'(i);
      b.cti = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      b.we  = we;
      b.sel = sel;
      b.dat = we ? wbuf[i] : 32'h0;
      exp_bus.push_back(b);
    end
  endtask

  task automatic issue_cmd(input logic we, input logic [7:0] adr, input logic [LW-1:0] len, input logic [3:0] sel);
    int k;
    @(posedge HCLK); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_sel = sel;
    k = 0;
    do begin
      @(negedge HCLK);
      k++;
    end while (!cmd_ready && k < 50);
    if (!cmd_ready) begin
      $display("FAIL cmd_ready_wait got 0 want 1 within 50 cycles");
      $fatal(1, "command not accepted");
    end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge HCLK);
      k++;
    end while (!done && k < 100);
    if (!done) begin
      $display("FAIL done_wait got no done want done within 100 cycles");
      $fatal(1, "command never completed");
    end
    @(posedge HCLK); #1;
  endtask

  task automatic run_write(input logic [7:0] adr, input logic [LW-1:0] len, input logic [3:0] sel,
                           input int n, input int gap_at, input int gap_len);
    int k;
    done_t d;
    push_burst(adr, n, 1'b1, sel);
    d.err = 1'b0; d.stbs = 8'(n);
    exp_done.push_back(d);
    issue_cmd(1'b1, adr, len, sel);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        wdat_valid = 1'b0;
        chk_starve = 1'b1;
        repeat (gap_len) @(negedge HCLK);
        @(posedge HCLK); #1;
        chk_starve = 1'b0;
      end
      wdat = wbuf[i];
      wdat_valid = 1'b1;
      k = 0;
      do begin
        @(negedge HCLK);
        k++;
      end while (!wdat_ready && k < 50);
      if (!wdat_ready) begin
        $display("FAIL wdat_ready_wait got 0 want 1 within 50 cycles");
        $fatal(1, "write beat never consumed");
      end
      @(posedge HCLK); #1;
    end
    wdat_valid = 1'b0;
    wdat = 32'h0;
    wait_done();
  endtask

  task automatic run_read(input logic [7:0] adr, input logic [LW-1:0] len, input int n);
    done_t d;
    push_burst(adr, n, 1'b0, 4'hF);
    for (int i = 0; i < n; i++) exp_rdat.push_back(rexp[i]);
    d.err = 1'b0; d.stbs = 8'(n);
    exp_done.push_back(d);
    issue_cmd(1'b0, adr, len, 4'hF);
    wait_done();
  endtask

  initial begin
    done_t d;
    bus_t  b;
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 8'h00; cmd_len = 5'd0; cmd_sel = 4'h0;
    wdat = 32'h0; wdat_valid = 1'b0;
    ack_en = 1'b1; err_en = 1'b0; err_adr = 8'h00;
    chk_idle = 1'b1; chk_starve = 1'b0; chk_end = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    @(posedge HCLK); #1;
    chk_idle = 1'b0;

    // Single classic write, then read back with len=0 (treated as one beat).
    wbuf[0] = 32'hDEADBEEF;
    run_write(8'h10, 5'd1, 4'hF, 1, -1, 0);
    rexp[0] = 32'hDEADBEEF;
    run_read(8'h10, 5'd0, 1);

    // Partial byte-lane write touches only the low half-word.
    wbuf[0] = 32'h12345678;
    run_write(8'h10, 5'd1, 4'h3, 1, -1, 0);
    rexp[0] = 32'hDEAD5678;
    run_read(8'h10, 5'd1, 1);

    // Four-beat burst write and read back.
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h3; wbuf[3] = 32'h4;
    run_write(8'h20, 5'd4, 4'hF, 4, -1, 0);
    rexp[0] = 32'h1; rexp[1] = 32'h2; rexp[2] = 32'h3; rexp[3] = 32'h4;
    run_read(8'h20, 5'd4, 4);

    // Address wraps from 0xFF to 0x00.
    wbuf[0] = 32'hA0A0_00FF; wbuf[1] = 32'hB1B1_0000; wbuf[2] = 32'hC2C2_0001;
    run_write(8'hFF, 5'd3, 4'hF, 3, -1, 0);
    rexp[0] = 32'hA0A0_00FF; rexp[1] = 32'hB1B1_0000; rexp[2] = 32'hC2C2_0001;
    run_read(8'hFF, 5'd3, 3);
    rexp[0] = 32'hB1B1_0000; rexp[1] = 32'hC2C2_0001;
    run_read(8'h00, 5'd2, 2);

    // Write data starved longer than TIMEOUT mid-burst must not abort.
    wbuf[0] = 32'h600; wbuf[1] = 32'h601; wbuf[2] = 32'h602; wbuf[3] = 32'h603;
    run_write(8'h60, 5'd4, 4'hF, 4, 2, 10);
    rexp[0] = 32'h600; rexp[1] = 32'h601; rexp[2] = 32'h602; rexp[3] = 32'h603;
    run_read(8'h60, 5'd4, 4);

    // Oversized length clamps to 16 beats of never-written (zero) memory.
    for (int i = 0; i < 16; i++) rexp[i] = 32'h0;
    run_read(8'h80, 5'd31, 16);

    // Slave error on beat 2 of a 4-beat read (ack is also high there): one data beat, error done.
    err_en = 1'b1; err_adr = 8'h21;
    b.adr = 8'h20; b.cti = 3'b010; b.we = 1'b0; b.sel = 4'hF; b.dat = 32'h0;
    exp_bus.push_back(b);
    exp_rdat.push_back(32'h1);
    d.err = 1'b1; d.stbs = 8'd2;
    exp_done.push_back(d);
    issue_cmd(1'b0, 8'h20, 5'd4, 4'hF);
    wait_done();
    err_en = 1'b0;

    // Slave never acks: abort after exactly TIMEOUT strobe cycles.
    ack_en = 1'b0;
    d.err = 1'b1; d.stbs = 8'd8;
    exp_done.push_back(d);
    issue_cmd(1'b0, 8'h30, 5'd2, 4'hF);
    wait_done();

    // Reset in the middle of a stalled burst: bus drops at once, no done.
    issue_cmd(1'b0, 8'h40, 5'd8, 4'hF);
    repeat (3) @(posedge HCLK);
    #2 HRESETn = 1'b0;
    chk_idle = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    @(posedge HCLK); #1;
    chk_idle = 1'b0;
    ack_en = 1'b1;

    // Master is usable again after the reset.
    rexp[0] = 32'h1;
    run_read(8'h20, 5'd1, 1);

    repeat (3) @(posedge HCLK);
    #1 chk_end = 1'b1;
    @(negedge HCLK);
    @(posedge HCLK); #1;
    chk_end = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
